fp_divider: RTL and testbench

//  Iterative IEEE-754 single-precision divider (quot = A / B), the inverse

---
 rtl/fp_divider.sv | 186 ++++++++++++++++++
 tb/tb_fp_divider.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp_divider.sv
// rtl/fp_divider.sv - iterative IEEE-754 single-precision restoring divider, optional FP_DIV_EARLY_EXIT_EN
module fp_divider #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int BIAS  = 127
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   A,
   input  logic [EXP_W+MAN_W:0]   B,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   quot,
   output logic                   exception,
   output logic                   div_zero,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int W       = EXP_W + MAN_W + 1;
   localparam int QBITS   = MAN_W + 3;
   localparam int CNT_W   = $clog2(QBITS);
   localparam int EW      = EXP_W + 2;
   localparam int EXP_MAX = (1 << EXP_W) - 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DIVIDE = 2'd1;
   localparam logic [1:0] ROUND  = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             sign_r, exc_r, dz_r, az_r;
   logic [EXP_W-1:0] ea_r, eb_r;
   logic [MAN_W:0]   divisor;
   logic [QBITS-1:0] rem, q;

   // Special-case results share one encoding: {exception, div_zero, overflow, underflow, quot}
   function automatic logic [W+3:0] special_result(input logic s, input logic exc, input logic dz);
      if (exc)
         special_result = {4'b1000, {W{1'b0}}};
      else if (dz)
         special_result = {4'b0100, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else
         special_result = {4'b0000, s, {(W-1){1'b0}}};
   endfunction

   logic             in_sign, in_exc, in_dz, in_az;
   logic [EXP_W-1:0] in_ea, in_eb;

   // Decode operand classes straight from the inputs at accept time
   always_comb begin
      in_ea   = A[W-2:MAN_W];
      in_eb   = B[W-2:MAN_W];
      in_sign = A[W-1] ^ B[W-1];
      in_exc  = (&in_ea) | (&in_eb);
      in_dz   = ~(|in_eb);
      in_az   = ~(|in_ea);
   end

   logic [QBITS-1:0] div_ext, rem_nx;
   logic             ge;

   // One restoring step: subtract the divisor when it fits, that decides the next quotient bit
   always_comb begin
      div_ext = {{(QBITS-MAN_W-1){1'b0}}, divisor};
      ge      = (rem >= div_ext);
      rem_nx  = ge ? (rem - div_ext) : rem;
   end

   logic             qhi, rbit, sbit, round_up, carry;
   logic [MAN_W-1:0] mant_pre, mant_fin;
   logic [MAN_W:0]   mant_inc;
   logic signed [EW-1:0] e_base, e_pre, e_fin;
   logic             ovf, unf;
   logic [W+3:0]     res;

   // Normalise on the quotient MSB, round to nearest even, then apply result priority
   always_comb begin
      qhi = q[QBITS-1];
      if (qhi) begin
         mant_pre = q[QBITS-2:2];
         rbit     = q[1];
         sbit     = q[0] | (|rem);
      end else begin
         mant_pre = q[QBITS-3:1];
         rbit     = q[0];
         sbit     = |rem;
      end
      e_base   = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + $signed(EW'(BIAS));
      e_pre    = qhi ? e_base : (e_base - $signed(EW'(1)));
      round_up = rbit & (sbit | mant_pre[0]);
      mant_inc = {1'b0, mant_pre} + {{MAN_W{1'b0}}, round_up};
      carry    = mant_inc[MAN_W];
      mant_fin = mant_inc[MAN_W-1:0];
      e_fin    = e_pre + $signed({{(EW-1){1'b0}}, carry});
      ovf      = !e_fin[EW-1] && (e_fin[EW-2:0] >= (EW-1)'(EXP_MAX));
      unf      = e_fin[EW-1] || (e_fin == '0);
      if (exc_r || dz_r || az_r)
         res = special_result(sign_r, exc_r, dz_r);
      else if (ovf)
         res = {4'b0010, sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else if (unf)
         res = {4'b0001, sign_r, {(W-1){1'b0}}};
      else
         res = {4'b0000, sign_r, e_fin[EXP_W-1:0], mant_fin};
   end

   logic [W+3:0] early_res;
   assign early_res = special_result(in_sign, in_exc, in_dz);

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sign_r    <= 1'b0;
         exc_r     <= 1'b0;
         dz_r      <= 1'b0;
         az_r      <= 1'b0;
         ea_r      <= '0;
         eb_r      <= '0;
         divisor   <= '0;
         rem       <= '0;
         q         <= '0;
         quot      <= '0;
         exception <= 1'b0;
         div_zero  <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_r  <= in_sign;
                  exc_r   <= in_exc;
                  dz_r    <= in_dz;
                  az_r    <= in_az;
                  ea_r    <= in_ea;
                  eb_r    <= in_eb;
                  divisor <= {~in_dz, B[MAN_W-1:0]};
                  rem     <= {{(QBITS-MAN_W-1){1'b0}}, ~in_az, A[MAN_W-1:0]};
                  q       <= '0;
                  cnt     <= '0;
`ifdef FP_DIV_EARLY_EXIT_EN
                  if (in_exc || in_dz || in_az) begin
                     {exception, div_zero, overflow, underflow, quot} <= early_res;
                     state <= DONE;
                  end else begin
                     state <= DIVIDE;
                  end
`else
                  state <= DIVIDE;
`endif
               end
            end
            DIVIDE: begin
               q   <= {q[QBITS-2:0], ge};
               rem <= {rem_nx[QBITS-2:0], 1'b0};
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(QBITS - 1))
                  state <= ROUND;
            end
            ROUND: begin
               {exception, div_zero, overflow, underflow, quot} <= res;
               state <= DONE;
            end
            default: begin
               if (out_ready)
                  state <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

`ifndef FP_DIV_EARLY_EXIT_EN
   logic unused_early;
   assign unused_early = ^early_res;
`endif

endmodule

// File: tb/tb_fp_divider.sv
// tb/tb_fp_divider.sv - self-checking bench for fp_divider against an arithmetic model
module tb_fp_divider;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] quot;
   logic        exception, div_zero, overflow, underflow;

   int checks = 0;
   int errors = 0;
   logic [35:0] exp_q[$];

   fp_divider dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .quot(quot), .exception(exception), .div_zero(div_zero),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, expv);
      end
   endtask

   // Result as {exception, div_zero, overflow, underflow, quot}, from real-number rules
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
      logic   s;
      int     ea, eb, e;
      longint n, d, qq, rr;
      logic [63:0] qv;
      logic [23:0] m;
      logic   rb, sb;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 255 || eb == 255) return {4'b1000, 32'h0};
      if (eb == 0) return {4'b0100, s, 8'hFF, 23'h0};
      if (ea == 0) return {4'b0000, s, 31'h0};
      n  = longint'({1'b1, a[22:0]});
      d  = longint'({1'b1, b[22:0]});
      qq = (n * 33554432) / d;
      rr = (n * 33554432) % d;
      qv = 64'(qq);
      e  = ea - eb + 127;
      if (qq >= 33554432) begin
         m  = {1'b0, qv[24:2]};
         rb = qv[1];
         sb = qv[0] | (rr != 0);
      end else begin
         m  = {1'b0, qv[23:1]};
         rb = qv[0];
         sb = (rr != 0);
         e  = e - 1;
      end
      if (rb && (sb || m[0])) m = m + 1;
      if (m[23]) begin
         m = '0;
         e = e + 1;
      end
      if (e >= 255) return {4'b0010, s, 8'hFF, 23'h0};
      if (e <= 0) return {4'b0001, s, 31'h0};
      return {4'b0000, s, 8'(e), m[22:0]};
   endfunction

   // Compare the presented result against the oldest expected one on every valid cycle
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid got=%h expected=none", quot);
         end else begin
            chk("result", 64'({exception, div_zero, overflow, underflow, quot}), 64'(exp_q[0]));
         end
      end
   end

   always @(posedge clk) begin
      if (!rst && out_valid && out_ready && exp_q.size() > 0)
         void'(exp_q.pop_front());
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
      int guard;
      int lat;
      int exp_lat;
      logic special;
      @(negedge clk);
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
      special = (&a[30:23]) | (&b[30:23]) | (b[30:23] == 8'h0) | (a[30:23] == 8'h0);
`ifdef FP_DIV_EARLY_EXIT_EN
      exp_lat = special ? 1 : 28;
`else
      exp_lat = 28;
      special = 1'b0;
`endif
      exp_q.push_back(model(a, b));
      A = a;
      B = b;
      in_valid = 1'b1;
      out_ready = (hold == 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = $urandom;
      B = $urandom;
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("latency", 64'(lat), 64'(exp_lat));
      if (hold > 0) begin
         repeat (hold) begin
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk);
         end
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("released", 64'({in_ready, out_valid}), 64'b10);
   endtask

   logic [31:0] ra, rb;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_state", 64'({in_ready, out_valid, exception, div_zero, overflow, underflow, quot}),
          64'({1'b1, 1'b0, 4'b0, 32'h0}));

      chk("model_6_div_2", 64'(model(32'h40C00000, 32'h40000000)), 64'h0_40400000);
      chk("model_1_div_3", 64'(model(32'h3F800000, 32'h40400000)), 64'h0_3EAAAAAB);
      chk("model_div_zero", 64'(model(32'hBF800000, 32'h00000000)), 64'h4_FF800000);
      chk("model_overflow", 64'(model(32'h7F000000, 32'h00800000)), 64'h2_7F800000);
      chk("model_underflow", 64'(model(32'h00800000, 32'h7F000000)), 64'h1_00000000);
      chk("model_nan", 64'(model(32'h7FC00000, 32'h3F800000)), 64'h8_00000000);
      chk("model_neg", 64'(model(32'h40A00000, 32'hC0800000)), 64'h0_BFA00000);

      run_op(32'h40C00000, 32'h40000000, 0);
      run_op(32'h3F800000, 32'h40400000, 0);
      run_op(32'hBF800000, 32'h00000000, 0);
      run_op(32'h7F000000, 32'h00800000, 0);
      run_op(32'h00800000, 32'h7F000000, 0);
      run_op(32'h7FC00000, 32'h3F800000, 0);
      run_op(32'h3F800000, 32'h7F800000, 0);
      run_op(32'h3F800000, 32'h80000000, 0);
      run_op(32'h00000000, 32'h40400000, 0);
      run_op(32'h80000000, 32'h40000000, 0);
      run_op(32'h40A00000, 32'hC0800000, 0);
      run_op(32'h3FFFFFFF, 32'h3F800000, 0);
      run_op(32'h3F800000, 32'h3F800000, 0);
      run_op(32'h3F800000, 32'h3FFFFFFF, 0);
      run_op(32'h3F800000, 32'h40400000, 5);

      for (int i = 0; i < 12; i++) begin
         ra = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
         rb = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
         run_op(ra, rb, 0);
      end

      exp_q.push_back(model(32'h40C00000, 32'h40000000));
      @(negedge clk);
      A = 32'h40C00000;
      B = 32'h40000000;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_mid_op", 64'({in_ready, out_valid, quot}), 64'({1'b1, 1'b0, 32'h0}));
      begin
         int seen;
         seen = 0;
         repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
         end
         chk("no_stale_result", 64'(seen), 64'd0);
      end

      run_op(32'h40C00000, 32'h40000000, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
